// File: rtl/exec_stage_mdu.sv
// Execute stage: combinational ALU, store-data forwarding and an iterative multiply/divide unit owning HI/LO.
// Define EXEC_MDU_DIV_EN to build the restoring divider; otherwise DIV/DIVU decode as no-ops.
module exec_stage_mdu #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [3:0]        aluOperation,
    input  logic              shiftUseShamt,
    input  logic              aluBUseImmediate,
    input  logic [DATA_W-1:0] immediate,
    input  logic [DATA_W-1:0] registerRsOrPc_4,
    input  logic [DATA_W-1:0] registerRtOrZero,
    input  logic [1:0]        storeFwdSel,
    input  logic [DATA_W-1:0] memAluResult,
    input  logic [DATA_W-1:0] memMemoryData,
    input  logic [DATA_W-1:0] wbWriteData,
    input  logic [2:0]        mduOp,
    output logic [DATA_W-1:0] aluOutput,
    output logic [DATA_W-1:0] writeDataToDataRAM,
    output logic              stall,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    localparam int SH_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mduState_t;

    mduState_t           state;
    logic [CNT_W-1:0]    count;
    logic [2*DATA_W-1:0] acc;
    logic [DATA_W-1:0]   operandM;
    logic                negLo;

    // ---------------- ALU path ----------------
    logic [DATA_W-1:0] aluA;
    logic [DATA_W-1:0] aluB;
    logic [SH_W-1:0]   shamt;
    logic [DATA_W-1:0] aluResult;

    assign aluA  = shiftUseShamt ? ((immediate >> 6) & DATA_W'(31)) : registerRsOrPc_4;
    assign aluB  = aluBUseImmediate ? immediate : registerRtOrZero;
    assign shamt = aluA[SH_W-1:0];

    always_comb begin
        aluResult = '0;
        case (aluOperation)
            4'd0:    aluResult = aluA & aluB;
            4'd1:    aluResult = aluA | aluB;
            4'd2:    aluResult = aluA + aluB;
            4'd3:    aluResult = aluA ^ aluB;
            4'd4:    aluResult = ~(aluA | aluB);
            4'd5:    aluResult = aluB << shamt;
            4'd6:    aluResult = aluB >> shamt;
            4'd7:    aluResult = $signed(aluB) >>> shamt;
            4'd8:    aluResult = aluA - aluB;
            4'd9:    aluResult = DATA_W'($signed(aluA) < $signed(aluB));
            4'd10:   aluResult = DATA_W'(aluA < aluB);
            4'd11:   aluResult = aluB << 16;
            default: aluResult = '0;
        endcase
    end

    always_comb begin
        aluOutput = aluResult;
        if (mduOp == 3'd5)
            aluOutput = hi;
        else if (mduOp == 3'd6)
            aluOutput = lo;
    end

    always_comb begin
        writeDataToDataRAM = registerRtOrZero;
        case (storeFwdSel)
            2'd1:    writeDataToDataRAM = memAluResult;
            2'd2:    writeDataToDataRAM = memMemoryData;
            2'd3:    writeDataToDataRAM = wbWriteData;
            default: writeDataToDataRAM = registerRtOrZero;
        endcase
    end

    // ---------------- MDU decode and operand magnitudes ----------------
    logic              isStart;
    logic              isSigned;
    logic              signA;
    logic              signB;
    logic [DATA_W-1:0] magA;
    logic [DATA_W-1:0] magB;

`ifdef EXEC_MDU_DIV_EN
    logic opDivReq;
    assign opDivReq = (mduOp == 3'd3) || (mduOp == 3'd4);
    assign isStart  = (mduOp >= 3'd1) && (mduOp <= 3'd4);
`else
    assign isStart  = (mduOp == 3'd1) || (mduOp == 3'd2);
`endif

    assign isSigned = (mduOp == 3'd1) || (mduOp == 3'd3);
    assign signA    = isSigned & registerRsOrPc_4[DATA_W-1];
    assign signB    = isSigned & registerRtOrZero[DATA_W-1];
    assign magA     = signA ? -registerRsOrPc_4 : registerRsOrPc_4;
    assign magB     = signB ? -registerRtOrZero : registerRtOrZero;

    assign stall = (state == BUSY) || ((state == IDLE) && isStart && !flush);

    // ---------------- Iteration step ----------------
    // acc holds {partial, low operand}: multiplier shifts out of the bottom
    // while product bits enter the top; for divide the upper half is the
    // running remainder and the lower half collects quotient bits.
    logic [DATA_W:0]     mulSum;
    logic [2*DATA_W-1:0] mulNext;
    logic [2*DATA_W-1:0] stepNext;

    assign mulSum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, operandM} : '0);
    assign mulNext = {mulSum, acc[DATA_W-1:1]};

`ifdef EXEC_MDU_DIV_EN
    logic              isDiv;
    logic              negHi;
    logic              divByZero;
    logic [DATA_W-1:0] dividend;
    logic [DATA_W:0]   divShift;
    logic [DATA_W:0]   divDiff;
    logic [2*DATA_W-1:0] divNext;

    assign divShift = acc[2*DATA_W-1:DATA_W-1];
    assign divDiff  = divShift - {1'b0, operandM};
    assign divNext  = divDiff[DATA_W] ? {divShift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0}
                                      : {divDiff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
    assign stepNext = isDiv ? divNext : mulNext;
`else
    assign stepNext = mulNext;
`endif

    // ---------------- Result fix-up ----------------
    logic [DATA_W-1:0]   doneHi;
    logic [DATA_W-1:0]   doneLo;
    logic [2*DATA_W-1:0] product;

    assign product = negLo ? -acc : acc;

    always_comb begin
        {doneHi, doneLo} = product;
`ifdef EXEC_MDU_DIV_EN
        if (isDiv) begin
            if (divByZero) begin
                doneLo = '1;
                doneHi = dividend;
            end else begin
                doneLo = negLo ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
                doneHi = negHi ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
            end
        end
`endif
    end

    // ---------------- MDU sequencer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            hi       <= '0;
            lo       <= '0;
            acc      <= '0;
            operandM <= '0;
            negLo    <= 1'b0;
`ifdef EXEC_MDU_DIV_EN
            isDiv     <= 1'b0;
            negHi     <= 1'b0;
            divByZero <= 1'b0;
            dividend  <= '0;
`endif
        end else if (flush) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (isStart) begin
                        state    <= BUSY;
                        count    <= CNT_W'(DATA_W);
                        acc      <= {{DATA_W{1'b0}}, magA};
                        operandM <= magB;
                        negLo    <= signA ^ signB;
`ifdef EXEC_MDU_DIV_EN
                        isDiv     <= opDivReq;
                        negHi     <= signA;
                        divByZero <= (registerRtOrZero == '0);
                        dividend  <= registerRsOrPc_4;
`endif
                    end
                end
                BUSY: begin
                    acc   <= stepNext;
                    count <= count - 1'b1;
                    if (count == CNT_W'(1))
                        state <= DONE;
                end
                DONE: begin
                    hi    <= doneHi;
                    lo    <= doneLo;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exec_stage_mdu.sv
// Directed bench for exec_stage_mdu: ALU, store forwarding, MDU timing/results, flush/reset abort, 16-bit build.
module tb_exec_stage_mdu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [3:0]  aluOp = '0;
    logic        useShamt = 1'b0;
    logic        useImm = 1'b0;
    logic [31:0] imm = '0;
    logic [31:0] rs = '0;
    logic [31:0] rt = '0;
    logic [1:0]  fwdSel = '0;
    logic [31:0] memAlu = '0;
    logic [31:0] memData = '0;
    logic [31:0] wbData = '0;
    logic [2:0]  mduOp = '0;
    logic [31:0] aluOut;
    logic [31:0] storeData;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        rst16 = 1'b1;
    logic [15:0] rs16 = '0;
    logic [15:0] rt16 = '0;
    logic [2:0]  mduOp16 = '0;
    logic [15:0] aluOut16;
    logic [15:0] storeData16;
    logic        stall16;
    logic [15:0] hi16;
    logic [15:0] lo16;

    int checks = 0;
    int errors = 0;
    int cycles;
    logic [31:0] expHi;
    logic [31:0] expLo;

    always #5 clk = ~clk;

    exec_stage_mdu #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .aluOperation(aluOp),
        .shiftUseShamt(useShamt), .aluBUseImmediate(useImm), .immediate(imm),
        .registerRsOrPc_4(rs), .registerRtOrZero(rt), .storeFwdSel(fwdSel),
        .memAluResult(memAlu), .memMemoryData(memData), .wbWriteData(wbData),
        .mduOp(mduOp), .aluOutput(aluOut), .writeDataToDataRAM(storeData),
        .stall(stall), .hi(hi), .lo(lo)
    );

    exec_stage_mdu #(.DATA_W(16)) dut16 (
        .clk(clk), .rst(rst16), .flush(1'b0), .aluOperation(4'd0),
        .shiftUseShamt(1'b0), .aluBUseImmediate(1'b0), .immediate(16'h0),
        .registerRsOrPc_4(rs16), .registerRtOrZero(rt16), .storeFwdSel(2'd0),
        .memAluResult(16'h0), .memMemoryData(16'h0), .wbWriteData(16'h0),
        .mduOp(mduOp16), .aluOutput(aluOut16), .writeDataToDataRAM(storeData16),
        .stall(stall16), .hi(hi16), .lo(lo16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues an MDU op, counts stall-high cycles, and returns in the cycle after DONE.
    task automatic runMdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        mduOp = op; rs = a; rt = b;
        #1;
        n = 0;
        while (stall && n < 200) begin
            tick();
            n++;
        end
        tick();
        mduOp = 3'd0;
        #1;
    endtask

    initial begin
        tick(); tick();
        rst = 1'b0; rst16 = 1'b0;
        #1;
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_stall", {31'b0, stall}, 32'h0);

        aluOp = 4'd2; rs = 32'd5; rt = 32'hFFFF_FFFF; #1;
        chk("alu_add_wrap", aluOut, 32'd4);
        aluOp = 4'd9; rs = 32'hFFFF_FFFF; rt = 32'd1; #1;
        chk("alu_slt", aluOut, 32'd1);
        aluOp = 4'd10; #1;
        chk("alu_sltu", aluOut, 32'd0);
        aluOp = 4'd8; rs = 32'd3; rt = 32'd5; #1;
        chk("alu_sub_wrap", aluOut, 32'hFFFF_FFFE);
        aluOp = 4'd7; rs = 32'd4; rt = 32'h8000_0000; #1;
        chk("alu_sra", aluOut, 32'hF800_0000);
        aluOp = 4'd6; #1;
        chk("alu_srl", aluOut, 32'h0800_0000);
        aluOp = 4'd5; useShamt = 1'b1; imm = 32'h0000_0100; rt = 32'h1; #1;
        chk("alu_sll_shamt", aluOut, 32'h10);
        aluOp = 4'd11; useShamt = 1'b0; useImm = 1'b1; imm = 32'h0000_1234; #1;
        chk("alu_lui", aluOut, 32'h1234_0000);
        aluOp = 4'd4; useImm = 1'b0; rs = 32'h0F0F_0000; rt = 32'h0000_00F0; #1;
        chk("alu_nor", aluOut, 32'hF0F0_FF0F);
        aluOp = 4'd13; #1;
        chk("alu_undef", aluOut, 32'h0);
        aluOp = 4'd0;

        rt = 32'h11; memAlu = 32'h44; memData = 32'h22; wbData = 32'h33;
        fwdSel = 2'd0; #1; chk("fwd_rt", storeData, 32'h11);
        fwdSel = 2'd1; #1; chk("fwd_memalu", storeData, 32'h44);
        fwdSel = 2'd2; #1; chk("fwd_memdata", storeData, 32'h22);
        fwdSel = 2'd3; #1; chk("fwd_wb", storeData, 32'h33);
        fwdSel = 2'd0;

        runMdu(3'd1, 32'd7, 32'hFFFF_FFFD, cycles);
        chk("mult_stall_cycles", cycles, 32'd33);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFEB);
        mduOp = 3'd6; #1;
        chk("mflo", aluOut, 32'hFFFF_FFEB);
        mduOp = 3'd5; #1;
        chk("mfhi", aluOut, 32'hFFFF_FFFF);
        mduOp = 3'd0; #1;

        runMdu(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cycles);
        chk("multu_b2b_cycles", cycles, 32'd33);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);

`ifdef EXEC_MDU_DIV_EN
        runMdu(3'd4, 32'd100, 32'd7, cycles);
        chk("divu_cycles", cycles, 32'd33);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);
        runMdu(3'd3, 32'hFFFF_FFF9, 32'd2, cycles);
        chk("div_neg_lo", lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi, 32'hFFFF_FFFF);
        runMdu(3'd3, 32'd5, 32'd0, cycles);
        chk("div_zero_lo", lo, 32'hFFFF_FFFF);
        chk("div_zero_hi", hi, 32'd5);
        runMdu(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, cycles);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'h0);
        expHi = 32'h0; expLo = 32'h8000_0000;
`else
        runMdu(3'd3, 32'd9, 32'd3, cycles);
        chk("nodiv_div_cycles", cycles, 32'd0);
        chk("nodiv_div_hi", hi, 32'hFFFF_FFFE);
        chk("nodiv_div_lo", lo, 32'h0000_0001);
        runMdu(3'd4, 32'd9, 32'd3, cycles);
        chk("nodiv_divu_cycles", cycles, 32'd0);
        chk("nodiv_divu_lo", lo, 32'h0000_0001);
        expHi = 32'hFFFF_FFFE; expLo = 32'h0000_0001;
`endif

        // Flush abort at BUSY cycle 10.
        mduOp = 3'd2; rs = 32'hFFFF_FFFF; rt = 32'd2; #1;
        chk("flush_issue_stall", {31'b0, stall}, 32'h1);
        for (int i = 0; i < 10; i++) tick();
        flush = 1'b1; #1;
        chk("flush_busy_stall", {31'b0, stall}, 32'h1);
        tick();
        flush = 1'b0; mduOp = 3'd0; #1;
        chk("flush_stall_drop", {31'b0, stall}, 32'h0);
        for (int i = 0; i < 40; i++) tick();
        chk("flush_hi_kept", hi, expHi);
        chk("flush_lo_kept", lo, expLo);

        // Reset abort at BUSY cycle 10.
        mduOp = 3'd2; rs = 32'hFFFF_FFFF; rt = 32'd2; #1;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; mduOp = 3'd0; #1;
        chk("rst_stall_drop", {31'b0, stall}, 32'h0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);

        // Flush on the issue cycle: nothing starts.
        mduOp = 3'd1; rs = 32'd7; rt = 32'hFFFF_FFFD; flush = 1'b1; #1;
        chk("flush_at_issue_stall", {31'b0, stall}, 32'h0);
        tick();
        flush = 1'b0; mduOp = 3'd0; #1;
        chk("flush_at_issue_next", {31'b0, stall}, 32'h0);
        for (int i = 0; i < 40; i++) tick();
        chk("flush_at_issue_lo", lo, 32'h0);

        // 16-bit instance: 17 stall cycles for MULT.
        mduOp16 = 3'd1; rs16 = 16'd7; rt16 = 16'hFFFD; #1;
        cycles = 0;
        while (stall16 && cycles < 200) begin
            tick();
            cycles++;
        end
        tick();
        mduOp16 = 3'd0; #1;
        chk("w16_mult_cycles", cycles, 32'd17);
        chk("w16_mult_hi", {16'h0, hi16}, 32'h0000_FFFF);
        chk("w16_mult_lo", {16'h0, lo16}, 32'h0000_FFEB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
